rd_wptr_sync_level: RTL and testbench
=====================================

// Module: rd_wptr_sync_level
// PURPOSE
//  Read-domain receiver for the write-pointer crossing of the async FIFO. Brings the gray-coded
//  write pointer into rclk through a SYNC_STAGES flop chain, hands the synced pointer to the
//  read-pointer/empty logic, and derives a registered fill level, an almost-empty flag and a
//  sticky crossing-integrity error flag. Sits between the write-domain pointer register and the
//  read-side increment/empty logic.
// PARAMETERS
//  ADDRSIZE     4   FIFO address width; depth DEPTH = 2**ADDRSIZE, pointers ADDRSIZE+1 bits
//  SYNC_STAGES  2   synchronizer depth (legal >= 2)
//  AE_THRESH    1   almost_empty asserts when level <= AE_THRESH (0..DEPTH)
// PORTS
//  rclk                 in   1           read clock
//  rst                  in   1           reset, asynchronous, active-high
//  graycode_wptr_async  in   ADDRSIZE+1  gray write pointer from wclk domain (unsynchronized)
//  graycode_rptr        in   ADDRSIZE+1  registered gray read pointer, rclk domain
//  clr_err              in   1           synchronous clear of sync_err
//  graycode_wptr_sync   out  ADDRSIZE+1  synchronized gray write pointer (last sync stage)
//  rd_level             out  ADDRSIZE+1  registered fill level seen by the reader, 0..DEPTH
//  almost_empty         out  1           registered, rd_level <= AE_THRESH
//  sync_err             out  1           sticky integrity error
// BEHAVIOUR
//  - Reset (async, rst=1): all sync stages, graycode_wptr_sync, rd_level, prev-wbin reg = 0;
//    almost_empty = 1; sync_err = 0. Release is synchronous to next rclk edge.
//  - Sync chain: s[0] <= graycode_wptr_async; s[k] <= s[k-1]; graycode_wptr_sync = s[SYNC_STAGES-1].
//    No logic between stages. Input change visible on output after exactly SYNC_STAGES rclk edges.
//  - Gray->binary (combinational, both pointers): b[N]=g[N]; b[i]=b[i+1]^g[i], N=ADDRSIZE.
//  - diff = (wbin - rbin) mod 2**(ADDRSIZE+1), full ADDRSIZE+1-bit wrap arithmetic.
//  - Registered each cycle: rd_level <= diff; almost_empty <= (diff <= AE_THRESH).
//    Latency: wptr_sync or rptr change -> rd_level/almost_empty updated 1 cycle later.
//  - Pointer wrap (e.g. wbin 0x00 after 0x1F, ADDRSIZE=4) handled by mod arithmetic; no special case.
//  - Level is conservative: write side may be ahead of synced value; reader never over-reads.
//  - Step check: step = (wbin - wbin_prev) mod 2**(ADDRSIZE+1); wbin_prev <= wbin each cycle.
//    Multi-count steps are legal (fast wclk); step > DEPTH means backward motion -> error.
//  - Error sources (either sets sync_err next edge): diff > DEPTH, or step > DEPTH.
//  - sync_err: sticky; clr_err=1 clears it next edge; error event in same cycle as clr_err -> set wins.
//  - Step check disabled for the first cycle after reset release (wbin_prev not yet valid).
//  - Reset mid-operation: all state returns to reset values immediately regardless of rclk;
//    no error flagged on the pointer jump back to 0 after release.
// TESTING
//  - Reset: rst=1 mid-traffic -> immediately rd_level=0, almost_empty=1, sync_err=0, sync out=0.
//  - Latency: wptr_async 0->gray(1)=0x01, rptr=0 -> wptr_sync=0x01 after 2 edges,
//    rd_level=1, almost_empty=1 on 3rd edge; wptr to gray(5)=0x07 -> level 5, almost_empty=0.
//  - Wrap: rbin=30, wbin steps 30..33 mod 32 (=1) -> rd_level 0,1,2,3; no sync_err.
//  - Full: wbin=rbin+16 (ADDRSIZE=4) -> rd_level=16, sync_err=0; wbin=rbin+17 -> sync_err=1 next edge.
//  - Backward: wbin 10 then 9 -> step 31 > 16 -> sync_err=1; hold clr_err with no error -> 0;
//    clr_err concurrent with new error -> stays 1.
//  - Multi-step: wbin jumps 3 -> 9 in one cycle (fast wclk) -> rd_level tracks, sync_err stays 0.

Source files
------------

// File: rtl/rd_wptr_sync_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rd_wptr_sync_level                                           |
// | Description : Read-domain receiver for the async FIFO write pointer.       |
// |               Synchronizes the gray write pointer into rclk, derives a     |
// |               registered fill level, an almost-empty flag and a sticky     |
// |               crossing-integrity error flag.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rd_wptr_sync_level #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic [ADDRSIZE:0]   graycode_wptr_async,
  input  logic [ADDRSIZE:0]   graycode_rptr,
  input  logic                clr_err,
  output logic [ADDRSIZE:0]   graycode_wptr_sync,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                almost_empty,
  output logic                sync_err
);

  localparam int               c_PW    = ADDRSIZE + 1;
  // DEPTH = 2**ADDRSIZE fits exactly in the pointer width (MSB set).
  localparam logic [ADDRSIZE:0] c_DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] c_AE    = c_PW'(AE_THRESH);

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] r_sync [SYNC_STAGES];
  logic [ADDRSIZE:0] r_level;
  logic              r_ae;
  logic              r_err;
  logic [ADDRSIZE:0] r_wbin_prev;
  logic              r_prev_valid;

  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_diff;
  logic [ADDRSIZE:0] w_step;
  logic              w_err;

  // Plain flop chain for the clock crossing; nothing sits between stages.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= graycode_wptr_async;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign graycode_wptr_sync = r_sync[SYNC_STAGES-1];

  assign w_wbin = gray2bin(graycode_wptr_sync);
  assign w_rbin = gray2bin(graycode_rptr);
  // Wrap-around subtraction in pointer width gives occupancy and step directly.
  assign w_diff = w_wbin - w_rbin;
  assign w_step = w_wbin - r_wbin_prev;
  // Occupancy beyond DEPTH, or a step beyond DEPTH (backward motion), is corrupt.
  assign w_err  = (w_diff > c_DEPTH) | (r_prev_valid & (w_step > c_DEPTH));

  // Registered level/flags, previous write pointer and sticky error.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      r_level      <= '0;
      r_ae         <= 1'b1;
      r_err        <= 1'b0;
      r_wbin_prev  <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_level      <= w_diff;
      r_ae         <= (w_diff <= c_AE);
      r_err        <= w_err | (r_err & ~clr_err);
      r_wbin_prev  <= w_wbin;
      r_prev_valid <= 1'b1;
    end
  end

  assign rd_level     = r_level;
  assign almost_empty = r_ae;
  assign sync_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rd_wptr_sync_level.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rd_wptr_sync_level                                        |
// | Description : Self-checking bench for rd_wptr_sync_level: directed cases   |
// |               plus random traffic against a behavioural reference model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rd_wptr_sync_level;

  localparam int c_AW   = 4;
  localparam int c_SYNC = 2;
  localparam int c_AE   = 1;
  localparam int c_MOD  = 32;
  localparam int c_DEP  = 16;

  logic       rclk = 1'b0;
  logic       rst  = 1'b0;
  logic [4:0] wptr_async = '0;
  logic [4:0] rptr = '0;
  logic       clr_err = 1'b0;
  logic [4:0] wptr_sync;
  logic [4:0] rd_level;
  logic       almost_empty;
  logic       sync_err;

  int errors = 0;
  int checks = 0;

  rd_wptr_sync_level #(.ADDRSIZE(c_AW), .SYNC_STAGES(c_SYNC), .AE_THRESH(c_AE)) u_dut (
    .rclk                (rclk),
    .rst                 (rst),
    .graycode_wptr_async (wptr_async),
    .graycode_rptr       (rptr),
    .clr_err             (clr_err),
    .graycode_wptr_sync  (wptr_sync),
    .rd_level            (rd_level),
    .almost_empty        (almost_empty),
    .sync_err            (sync_err)
  );

  always #5 rclk = ~rclk;

  // Binary to gray.
  function automatic logic [4:0] gray(input int b);
    int g;
    g = (b ^ (b >> 1)) % c_MOD;
    return g[4:0];
  endfunction

  // Gray to binary by table search over all codes.
  function automatic int g2b(input int g);
    for (int b = 0; b < c_MOD; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of sampled async values, then occupancy rules.
  int m_pipe [c_SYNC];
  int m_level, m_prev;
  bit m_ae, m_err, m_valid;
  int mw, mr, mdiff, mstep;
  bit me;

  always @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_SYNC; k++) m_pipe[k] = 0;
      m_level = 0; m_ae = 1; m_err = 0; m_prev = 0; m_valid = 0;
    end else begin
      mw    = g2b(m_pipe[c_SYNC-1]);
      mr    = g2b(int'(rptr));
      mdiff = (mw - mr + c_MOD) % c_MOD;
      mstep = (mw - m_prev + c_MOD) % c_MOD;
      me    = (mdiff > c_DEP) || (m_valid && mstep > c_DEP);
      m_err   = me || (m_err && !clr_err);
      m_level = mdiff;
      m_ae    = (mdiff <= c_AE);
      m_prev  = mw;
      m_valid = 1;
      for (int k = c_SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = int'(wptr_async);
    end
  end

  // One rclk edge, then compare every output with the model mid-cycle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rclk);
      @(negedge rclk);
      chk("m_sync",  32'(wptr_sync),    32'(m_pipe[c_SYNC-1]));
      chk("m_level", 32'(rd_level),     32'(m_level));
      chk("m_ae",    32'(almost_empty), 32'(m_ae));
      chk("m_err",   32'(sync_err),     32'(m_err));
    end
  endtask

  task automatic set_ptrs(input int w, input int r);
    wptr_async = gray(w);
    rptr       = gray(r);
  endtask

  // Asynchronous reset asserted off the clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge rclk);
    #2 rst = 1'b1;
    #1;
    chk("rst_sync",  32'(wptr_sync),    32'd0);
    chk("rst_level", 32'(rd_level),     32'd0);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    chk("rst_err",   32'(sync_err),     32'd0);
    set_ptrs(0, 0);
    clr_err = 1'b0;
    @(negedge rclk);
    rst = 1'b0;
  endtask

  // Jump pointers while clearing, then leave a clean error flag.
  task automatic settle(input int w, input int r);
    clr_err = 1'b1;
    set_ptrs(w, r);
    tick(c_SYNC + 2);
    clr_err = 1'b0;
    tick(1);
    chk("settle_err", 32'(sync_err), 32'd0);
  endtask

  int tw, tr, lead;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("init_level", 32'(rd_level),     32'd0);
    chk("init_ae",    32'(almost_empty), 32'd1);
    chk("init_err",   32'(sync_err),     32'd0);
    chk("init_sync",  32'(wptr_sync),    32'd0);
    @(negedge rclk);
    rst = 1'b0;
    tick(2);

    // Latency: gray(1) reaches sync output on 2nd edge, level on 3rd.
    set_ptrs(1, 0);
    tick(1);
    chk("lat_sync1", 32'(wptr_sync), 32'd0);
    tick(1);
    chk("lat_sync2", 32'(wptr_sync), 32'h01);
    tick(1);
    chk("lat_level1", 32'(rd_level),     32'd1);
    chk("lat_ae1",    32'(almost_empty), 32'd1);
    set_ptrs(5, 0);
    tick(2);
    chk("lat_sync5", 32'(wptr_sync), 32'h07);
    tick(1);
    chk("lat_level5", 32'(rd_level),     32'd5);
    chk("lat_ae5",    32'(almost_empty), 32'd0);

    // Wrap: rbin=30, wbin 30..33 mod 32.
    settle(30, 30);
    chk("wrap_level0", 32'(rd_level), 32'd0);
    set_ptrs(31, 30); tick(1);
    set_ptrs(0, 30);  tick(1);
    set_ptrs(1, 30);  tick(1);
    chk("wrap_level1", 32'(rd_level), 32'd1);
    tick(1);
    chk("wrap_level2", 32'(rd_level), 32'd2);
    tick(1);
    chk("wrap_level3", 32'(rd_level), 32'd3);
    chk("wrap_err",    32'(sync_err), 32'd0);

    // Full and overfull.
    settle(5, 5);
    set_ptrs(21, 5);
    tick(3);
    chk("full_level", 32'(rd_level), 32'd16);
    chk("full_err",   32'(sync_err), 32'd0);
    set_ptrs(22, 5);
    tick(2);
    chk("over_err0", 32'(sync_err), 32'd0);
    tick(1);
    chk("over_err1", 32'(sync_err), 32'd1);

    // Backward motion, clear, and clear colliding with a new error.
    settle(10, 0);
    set_ptrs(9, 0);
    tick(3);
    chk("back_err", 32'(sync_err), 32'd1);
    clr_err = 1'b1;
    tick(1);
    chk("clr_err", 32'(sync_err), 32'd0);
    set_ptrs(8, 0);
    tick(3);
    chk("clr_vs_set", 32'(sync_err), 32'd1);
    clr_err = 1'b0;
    tick(1);
    chk("sticky", 32'(sync_err), 32'd1);

    // Multi-count step from a fast write clock.
    settle(3, 0);
    set_ptrs(9, 0);
    tick(3);
    chk("multi_level", 32'(rd_level), 32'd9);
    chk("multi_err",   32'(sync_err), 32'd0);

    // Random traffic against the model, with occasional corruption and resets.
    do_reset();
    tw = 0; tr = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        tw = 0; tr = 0;
      end
      tw   = (tw + int'($urandom_range(0, 3))) % c_MOD;
      lead = (tw - tr + c_MOD) % c_MOD;
      if (lead > c_DEP) tw = (tr + c_DEP) % c_MOD;
      lead = (tw - tr + c_MOD) % c_MOD;
      tr   = (tr + int'($urandom_range(0, (lead < 2) ? lead : 2))) % c_MOD;
      set_ptrs(tw, tr);
      if ($urandom_range(0, 39) == 0) wptr_async = 5'($urandom);
      clr_err = ($urandom_range(0, 7) == 0);
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
